// File: rtl/anc_sync_phase_seq_if.sv
// Sample-strobe / phase-stream bundle between the sequencer and the DDS stages.
// The slave modport belongs to the sequencer; master to the sample source and phase consumer.
interface anc_sync_phase_seq_if #(
   parameter int PHASE_WIDTH = 24,
   parameter int NCH         = 3
);
   logic                       smp_stb;
   logic [NCH*PHASE_WIDTH-1:0] ph_tdata;
   logic                       ph_tvalid;
   logic                       sym_start;
   logic                       frame_done;

   modport master (
      output smp_stb,
      input  ph_tdata,
      input  ph_tvalid,
      input  sym_start,
      input  frame_done
   );

   modport slave (
      input  smp_stb,
      output ph_tdata,
      output ph_tvalid,
      output sym_start,
      output frame_done
   );
endinterface

// File: rtl/anc_sync_phase_seq.sv
// ANC receive sync/phase sequencer: GPIO trigger, multi-segment sync preamble,
// then NCH per-sample phase accumulators with symbol-stepped increments.
module anc_sync_phase_seq #(
   parameter int PHASE_WIDTH    = 24,
   parameter int CNT_WIDTH      = 24,
   parameter int NCH            = 3,
   parameter int NSYNC_SEG      = 3,
   parameter int SYNC_SIG_N     = 8192,
   parameter int START_PH       = 0,
   parameter int GPIO_REG_WIDTH = 12,
   parameter int SYNC_IN_BIT    = 2,
   parameter int SYNC_OUT_BIT   = 0,
   parameter int RX_OUT_BIT     = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [GPIO_REG_WIDTH-1:0]  gpio_in,
   output logic [GPIO_REG_WIDTH-1:0]  gpio_out,
   input  logic                       abort,
   input  logic [CNT_WIDTH-1:0]       cfg_nsig,
   input  logic [CNT_WIDTH-1:0]       cfg_nsymb,
   input  logic [CNT_WIDTH-1:0]       cfg_nframes,
   input  logic [PHASE_WIDTH-1:0]     cfg_start_inc,
   input  logic [PHASE_WIDTH-1:0]     cfg_dph_inc,
   input  logic [NCH*PHASE_WIDTH-1:0] cfg_ch_inc,
   input  logic [NCH-1:0]             cfg_ch_mode,
   input  logic [NCH-1:0]             cfg_ch_dir,
   anc_sync_phase_seq_if.slave        ph,
   output logic [CNT_WIDTH-1:0]       sync_seg,
   output logic [1:0]                 state
);
   localparam logic [CNT_WIDTH-1:0]   C_SEG_LAST = CNT_WIDTH'(SYNC_SIG_N - 1);
   localparam logic [CNT_WIDTH-1:0]   C_NSEG_LAST = CNT_WIDTH'(NSYNC_SEG - 1);
   localparam logic [PHASE_WIDTH-1:0] C_START_PH = PHASE_WIDTH'(START_PH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                     r_state, w_state_nxt;
   logic [1:0]                 r_sync;
   logic                       r_sync_q;
   logic [CNT_WIDTH-1:0]       r_sync_cnt, r_sync_seg;
   logic [CNT_WIDTH-1:0]       r_nsig, r_nsymb, r_nframes;
   logic [PHASE_WIDTH-1:0]     r_start_inc, r_dph_inc, r_step;
   logic [NCH*PHASE_WIDTH-1:0] r_ch_inc;
   logic [NCH-1:0]             r_mode, r_dir;
   logic [CNT_WIDTH-1:0]       r_sig_cnt, r_sym_cnt, r_frame_cnt;
   logic [PHASE_WIDTH-1:0]     r_ph [NCH];
   logic [NCH*PHASE_WIDTH-1:0] r_ph_tdata;
   logic                       r_ph_tvalid, r_sym_start, r_frame_done;

   logic                       w_trig, w_seg_end, w_sync_done;
   logic                       w_run_stb, w_sig_last, w_sym_last, w_all_done;
   logic [CNT_WIDTH-1:0]       w_frame_nxt;
   logic [PHASE_WIDTH-1:0]     w_inc [NCH];
   logic [PHASE_WIDTH-1:0]     w_ph_adv [NCH];
   logic                       w_unused_gpio;

   assign w_unused_gpio = ^gpio_in;
   assign w_trig        = r_sync[1] & ~r_sync_q;
   assign w_seg_end     = (r_sync_cnt == C_SEG_LAST);
   assign w_sync_done   = w_seg_end && (r_sync_seg == C_NSEG_LAST);
   assign w_run_stb     = (r_state == ST_RUN) && ph.smp_stb && !abort;
   assign w_sig_last    = (r_sig_cnt == r_nsig - 1'b1);
   assign w_sym_last    = (r_sym_cnt == r_nsymb - 1'b1);
   assign w_frame_nxt   = r_frame_cnt + 1'b1;
   assign w_all_done    = w_run_stb && w_sig_last && w_sym_last &&
                          (r_nframes != '0) && (w_frame_nxt == r_nframes);

   always_comb begin
      for (int unsigned k = 0; k < NCH; k++) begin
         w_inc[k]    = r_ch_inc[k*PHASE_WIDTH +: PHASE_WIDTH] + (r_mode[k] ? r_step : '0);
         w_ph_adv[k] = r_dir[k] ? (r_ph[k] - w_inc[k]) : (r_ph[k] + w_inc[k]);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_trig)      w_state_nxt = ST_SYNC;
         ST_SYNC: if (w_sync_done) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_all_done)  w_state_nxt = ST_DONE;
         ST_DONE:                  w_state_nxt = ST_IDLE;
         default:                  w_state_nxt = ST_IDLE;
      endcase
      if (abort) w_state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync       <= '0;
         r_sync_q     <= 1'b0;
         r_sync_cnt   <= '0;
         r_sync_seg   <= '0;
         r_nsig       <= '0;
         r_nsymb      <= '0;
         r_nframes    <= '0;
         r_start_inc  <= '0;
         r_dph_inc    <= '0;
         r_step       <= '0;
         r_ch_inc     <= '0;
         r_mode       <= '0;
         r_dir        <= '0;
         r_sig_cnt    <= '0;
         r_sym_cnt    <= '0;
         r_frame_cnt  <= '0;
         r_ph_tdata   <= '0;
         r_ph_tvalid  <= 1'b0;
         r_sym_start  <= 1'b0;
         r_frame_done <= 1'b0;
         for (int unsigned k = 0; k < NCH; k++) r_ph[k] <= '0;
      end else begin
         r_sync       <= {r_sync[0], gpio_in[SYNC_IN_BIT]};
         r_sync_q     <= r_sync[1];
         r_ph_tvalid  <= 1'b0;
         r_sym_start  <= 1'b0;
         r_frame_done <= 1'b0;
         // abort drops any trigger or strobe this cycle and leaves phases frozen
         if (!abort) begin
            case (r_state)
               ST_IDLE: if (w_trig) begin
                  r_nsig      <= (cfg_nsig  == '0) ? CNT_WIDTH'(1) : cfg_nsig;
                  r_nsymb     <= (cfg_nsymb == '0) ? CNT_WIDTH'(1) : cfg_nsymb;
                  r_nframes   <= cfg_nframes;
                  r_start_inc <= cfg_start_inc;
                  r_dph_inc   <= cfg_dph_inc;
                  r_ch_inc    <= cfg_ch_inc;
                  r_mode      <= cfg_ch_mode;
                  r_dir       <= cfg_ch_dir;
                  r_sync_cnt  <= '0;
                  r_sync_seg  <= '0;
               end
               ST_SYNC: if (w_seg_end) begin
                  r_sync_cnt <= '0;
                  if (w_sync_done) begin
                     r_sig_cnt   <= '0;
                     r_sym_cnt   <= '0;
                     r_frame_cnt <= '0;
                     r_step      <= r_start_inc;
                     for (int unsigned k = 0; k < NCH; k++) r_ph[k] <= C_START_PH;
                  end else begin
                     r_sync_seg <= r_sync_seg + 1'b1;
                  end
               end else begin
                  r_sync_cnt <= r_sync_cnt + 1'b1;
               end
               ST_RUN: if (w_run_stb) begin
                  r_ph_tvalid <= 1'b1;
                  r_sym_start <= (r_sig_cnt == '0);
                  for (int unsigned k = 0; k < NCH; k++)
                     r_ph_tdata[k*PHASE_WIDTH +: PHASE_WIDTH] <= r_ph[k];
                  if (w_sig_last) begin
                     r_sig_cnt <= '0;
                     for (int unsigned k = 0; k < NCH; k++) r_ph[k] <= C_START_PH;
                     if (w_sym_last) begin
                        r_sym_cnt    <= '0;
                        r_step       <= r_start_inc;
                        r_frame_cnt  <= w_frame_nxt;
                        r_frame_done <= 1'b1;
                     end else begin
                        r_sym_cnt <= r_sym_cnt + 1'b1;
                        r_step    <= r_step + r_dph_inc;
                     end
                  end else begin
                     r_sig_cnt <= r_sig_cnt + 1'b1;
                     for (int unsigned k = 0; k < NCH; k++) r_ph[k] <= w_ph_adv[k];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      gpio_out = '0;
      if (r_state == ST_SYNC) gpio_out[SYNC_OUT_BIT] = 1'b1;
      if (r_state == ST_RUN)  gpio_out[RX_OUT_BIT]   = 1'b1;
   end

   assign ph.ph_tdata   = r_ph_tdata;
   assign ph.ph_tvalid  = r_ph_tvalid;
   assign ph.sym_start  = r_sym_start;
   assign ph.frame_done = r_frame_done;
   assign sync_seg      = r_sync_seg;
   assign state         = r_state;
endmodule

// File: tb/tb_anc_sync_phase_seq.sv
// Directed bench for anc_sync_phase_seq: two channels (ch0 add/stepped, ch1 subtract/fixed),
// short sync segments; inputs driven and outputs sampled on the falling clock edge.
module tb_anc_sync_phase_seq;
   localparam int PW   = 24;
   localparam int CW   = 24;
   localparam int NCH  = 2;
   localparam int NSEG = 3;
   localparam int SEGN = 16;
   localparam int GW   = 12;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [GW-1:0]     gpio_in = '0;
   logic [GW-1:0]     gpio_out;
   logic              abort = 1'b0;
   logic [CW-1:0]     cfg_nsig, cfg_nsymb, cfg_nframes;
   logic [PW-1:0]     cfg_start_inc, cfg_dph_inc;
   logic [NCH*PW-1:0] cfg_ch_inc;
   logic [NCH-1:0]    cfg_ch_mode, cfg_ch_dir;
   logic [CW-1:0]     sync_seg;
   logic [1:0]        state;

   int n_vec = 0;
   int n_err = 0;

   logic [PW-1:0] exp0 [10] = '{24'd0, 24'd100, 24'd200, 24'd300, 24'd0,
                                24'd150, 24'd300, 24'd450, 24'd0, 24'd100};
   logic [PW-1:0] exp1 [10] = '{24'h000000, 24'hFFFFF0, 24'hFFFFE0, 24'hFFFFD0, 24'h000000,
                                24'hFFFFF0, 24'hFFFFE0, 24'hFFFFD0, 24'h000000, 24'hFFFFF0};

   anc_sync_phase_seq_if #(.PHASE_WIDTH(PW), .NCH(NCH)) ph_if ();

   anc_sync_phase_seq #(
      .PHASE_WIDTH(PW), .CNT_WIDTH(CW), .NCH(NCH), .NSYNC_SEG(NSEG),
      .SYNC_SIG_N(SEGN), .START_PH(0), .GPIO_REG_WIDTH(GW),
      .SYNC_IN_BIT(2), .SYNC_OUT_BIT(0), .RX_OUT_BIT(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .gpio_in(gpio_in), .gpio_out(gpio_out),
      .abort(abort), .cfg_nsig(cfg_nsig), .cfg_nsymb(cfg_nsymb),
      .cfg_nframes(cfg_nframes), .cfg_start_inc(cfg_start_inc),
      .cfg_dph_inc(cfg_dph_inc), .cfg_ch_inc(cfg_ch_inc),
      .cfg_ch_mode(cfg_ch_mode), .cfg_ch_dir(cfg_ch_dir),
      .ph(ph_if), .sync_seg(sync_seg), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, vectors=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   task set_cfg_default();
      cfg_nsig      = 24'd4;
      cfg_nsymb     = 24'd2;
      cfg_nframes   = 24'd0;
      cfg_start_inc = 24'd100;
      cfg_dph_inc   = 24'd50;
      cfg_ch_inc    = {24'h000010, 24'h000000};
      cfg_ch_mode   = 2'b01;
      cfg_ch_dir    = 2'b10;
   endtask

   task do_reset();
      reset_n = 1'b0; abort = 1'b0; ph_if.smp_stb = 1'b0; gpio_in = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Trigger edge held 5 clocks; RUN is reached 3 + NSEG*SEGN edges after the rise.
   task trigger_to_run();
      gpio_in[2] = 1'b1;
      for (int i = 0; i < 3 + NSEG*SEGN; i++) begin
         @(negedge clk);
         if (i == 4) gpio_in[2] = 1'b0;
      end
   endtask

   task test_reset();
      ph_if.smp_stb = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
      n_vec++;
      if (gpio_out !== 12'h000) begin n_err++; $display("FAIL reset_gpio: got %h want 000", gpio_out); end
      n_vec++;
      if ({ph_if.ph_tvalid, ph_if.sym_start, ph_if.frame_done} !== 3'b000) begin
         n_err++; $display("FAIL reset_pulses: got %b want 000",
                           {ph_if.ph_tvalid, ph_if.sym_start, ph_if.frame_done});
      end
      n_vec++;
      if ({ph_if.ph_tdata, sync_seg} !== '0) begin
         n_err++; $display("FAIL reset_data: tdata %h seg %0d want 0", ph_if.ph_tdata, sync_seg);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task test_sync();
      gpio_in[2] = 1'b1;
      for (int e = 1; e <= 2; e++) begin
         @(negedge clk);
         n_vec++;
         if (state !== 2'd0) begin n_err++; $display("FAIL sync_latency e%0d: got %0d want 0", e, state); end
      end
      for (int j = 0; j < NSEG*SEGN; j++) begin
         @(negedge clk);
         if (j == 2) gpio_in[2] = 1'b0;
         n_vec++;
         if ({state, gpio_out, sync_seg} !== {2'd1, 12'h001, CW'(j / SEGN)}) begin
            n_err++; $display("FAIL sync_seq j%0d: state %0d gpio %h seg %0d want 1 001 %0d",
                              j, state, gpio_out, sync_seg, j / SEGN);
         end
      end
      @(negedge clk);
      n_vec++;
      if ({state, gpio_out, ph_if.ph_tvalid} !== {2'd2, 12'h010, 1'b0}) begin
         n_err++; $display("FAIL sync_to_run: state %0d gpio %h tvalid %b want 2 010 0",
                           state, gpio_out, ph_if.ph_tvalid);
      end
   endtask

   task test_run_phase();
      for (int i = 0; i < 10; i++) begin
         ph_if.smp_stb = 1'b1;
         @(negedge clk);
         n_vec++;
         if ({ph_if.ph_tvalid, ph_if.ph_tdata, ph_if.sym_start, ph_if.frame_done} !==
             {1'b1, exp1[i], exp0[i], (i % 4 == 0), (i == 7)}) begin
            n_err++; $display("FAIL run_sample%0d: v%b d%h ss%b fd%b want v1 d%h%h ss%b fd%b",
                              i, ph_if.ph_tvalid, ph_if.ph_tdata, ph_if.sym_start, ph_if.frame_done,
                              exp1[i], exp0[i], (i % 4 == 0), (i == 7));
         end
      end
      ph_if.smp_stb = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({ph_if.ph_tvalid, state} !== {1'b0, 2'd2}) begin
         n_err++; $display("FAIL run_idle_strobe: tvalid %b state %0d want 0 2", ph_if.ph_tvalid, state);
      end
   endtask

   task test_gap_and_cfg_change();
      do_reset();
      set_cfg_default();
      trigger_to_run();
      n_vec++;
      if (state !== 2'd2) begin n_err++; $display("FAIL gap_reach_run: got %0d want 2", state); end
      for (int i = 0; i < 10; i++) begin
         ph_if.smp_stb = 1'b1;
         @(negedge clk);
         if (i == 5) begin
            cfg_nsig = 24'd2; cfg_nsymb = 24'd5; cfg_start_inc = 24'd7;
            cfg_dph_inc = 24'd9; cfg_ch_inc = {24'h000123, 24'h000456};
            cfg_ch_mode = 2'b10; cfg_ch_dir = 2'b01;
         end
         n_vec++;
         if ({ph_if.ph_tvalid, ph_if.ph_tdata, ph_if.sym_start, ph_if.frame_done} !==
             {1'b1, exp1[i], exp0[i], (i % 4 == 0), (i == 7)}) begin
            n_err++; $display("FAIL gap_sample%0d: v%b d%h ss%b fd%b want v1 d%h%h",
                              i, ph_if.ph_tvalid, ph_if.ph_tdata, ph_if.sym_start,
                              ph_if.frame_done, exp1[i], exp0[i]);
         end
         ph_if.smp_stb = 1'b0;
         for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            n_vec++;
            if (ph_if.ph_tvalid !== 1'b0) begin
               n_err++; $display("FAIL gap_no_valid%0d_%0d: got %b want 0", i, g, ph_if.ph_tvalid);
            end
         end
      end
      set_cfg_default();
      reset_n = 1'b0;
      #1;
      n_vec++;
      if ({state, gpio_out} !== {2'd0, 12'h000}) begin
         n_err++; $display("FAIL async_reset_run: state %0d gpio %h want 0 000", state, gpio_out);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task test_done();
      logic [PW-1:0] e1;
      do_reset();
      set_cfg_default();
      cfg_nsig = 24'd3; cfg_nsymb = 24'd1; cfg_nframes = 24'd2;
      trigger_to_run();
      n_vec++;
      if (state !== 2'd2) begin n_err++; $display("FAIL done_reach_run: got %0d want 2", state); end
      for (int i = 0; i < 6; i++) begin
         ph_if.smp_stb = 1'b1;
         @(negedge clk);
         e1 = 24'd0 - PW'(16 * (i % 3));
         n_vec++;
         if ({ph_if.ph_tvalid, ph_if.ph_tdata, ph_if.frame_done, state, gpio_out} !==
             {1'b1, e1, PW'(100 * (i % 3)), (i % 3 == 2), (i == 5) ? 2'd3 : 2'd2,
              (i == 5) ? 12'h000 : 12'h010}) begin
            n_err++; $display("FAIL done_sample%0d: v%b d%h fd%b st%0d gpio %h want d%h%h fd%b",
                              i, ph_if.ph_tvalid, ph_if.ph_tdata, ph_if.frame_done, state,
                              gpio_out, e1, PW'(100 * (i % 3)), (i % 3 == 2));
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_vec++;
         if ({state, ph_if.ph_tvalid} !== {2'd0, 1'b0}) begin
            n_err++; $display("FAIL done_to_idle%0d: state %0d tvalid %b want 0 0", i, state, ph_if.ph_tvalid);
         end
      end
      ph_if.smp_stb = 1'b0;
   endtask

   task test_zero_cfg();
      do_reset();
      set_cfg_default();
      cfg_nsig = 24'd0; cfg_nsymb = 24'd0; cfg_nframes = 24'd3;
      trigger_to_run();
      for (int i = 0; i < 3; i++) begin
         ph_if.smp_stb = 1'b1;
         @(negedge clk);
         n_vec++;
         if ({ph_if.ph_tvalid, ph_if.sym_start, ph_if.frame_done, ph_if.ph_tdata, state} !==
             {3'b111, 48'd0, (i == 2) ? 2'd3 : 2'd2}) begin
            n_err++; $display("FAIL zero_cfg%0d: v%b ss%b fd%b d%h st%0d want 111 0 %0d",
                              i, ph_if.ph_tvalid, ph_if.sym_start, ph_if.frame_done,
                              ph_if.ph_tdata, state, (i == 2) ? 3 : 2);
         end
      end
      ph_if.smp_stb = 1'b0;
      @(negedge clk);
      n_vec++;
      if (state !== 2'd0) begin n_err++; $display("FAIL zero_cfg_idle: got %0d want 0", state); end
   endtask

   task test_abort();
      do_reset();
      set_cfg_default();
      gpio_in[2] = 1'b1;
      repeat (8) @(negedge clk);
      n_vec++;
      if (state !== 2'd1) begin n_err++; $display("FAIL abort_pre_sync: got %0d want 1", state); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_vec++;
      if ({state, gpio_out} !== {2'd0, 12'h000}) begin
         n_err++; $display("FAIL abort_sync: state %0d gpio %h want 0 000", state, gpio_out);
      end
      gpio_in[2] = 1'b0;
      repeat (3) @(negedge clk);
      // the synchronised edge is presented during the third cycle after the rise
      gpio_in[2] = 1'b1;
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (state !== 2'd0) begin n_err++; $display("FAIL abort_trig_drop%0d: got %0d want 0", i, state); end
         @(negedge clk);
      end
      gpio_in[2] = 1'b0;
      repeat (3) @(negedge clk);
      trigger_to_run();
      n_vec++;
      if (state !== 2'd2) begin n_err++; $display("FAIL abort_restart: got %0d want 2", state); end
      for (int i = 0; i < 4; i++) begin
         ph_if.smp_stb = 1'b1;
         @(negedge clk);
         n_vec++;
         if ({ph_if.ph_tvalid, ph_if.ph_tdata} !== {1'b1, exp1[i], exp0[i]}) begin
            n_err++; $display("FAIL restart_sample%0d: v%b d%h want v1 d%h%h",
                              i, ph_if.ph_tvalid, ph_if.ph_tdata, exp1[i], exp0[i]);
         end
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_vec++;
      if ({state, gpio_out, ph_if.ph_tvalid, ph_if.sym_start} !== {2'd0, 12'h000, 2'b00}) begin
         n_err++; $display("FAIL abort_run: state %0d gpio %h v%b ss%b want 0 000 0 0",
                           state, gpio_out, ph_if.ph_tvalid, ph_if.sym_start);
      end
      @(negedge clk);
      n_vec++;
      if (ph_if.ph_tvalid !== 1'b0) begin
         n_err++; $display("FAIL idle_strobe: tvalid %b want 0", ph_if.ph_tvalid);
      end
      ph_if.smp_stb = 1'b0;
   endtask

   initial begin
      ph_if.smp_stb = 1'b0;
      set_cfg_default();
      test_reset();
      test_sync();
      test_run_phase();
      test_gap_and_cfg_change();
      test_done();
      test_zero_cfg();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/anc_sync_phase_seq.md
Name: anc_sync_phase_seq

Overview:
- Parametrised successor to the ANC receive controller's sync/phase sequencing logic, now a standalone block.
- Detects a front-panel GPIO sync trigger and runs a configurable multi-segment sync preamble.
- Then drives NCH per-sample phase accumulators (fixed or symbol-stepped increment, add or subtract) into downstream DDS/freq-shift stages, with runtime-configurable symbol length, symbol count and frame count.
- The DSP datapath (filters, mixers) stays outside; this block owns only timing, phase and GPIO status.

Parameters:
- PHASE_WIDTH, 24, phase accumulator/increment width.
- CNT_WIDTH, 24, width of nsig/nsymb/frame/sync counters.
- NCH, 3, number of phase channels.
- NSYNC_SEG, 3, sync segments between trigger and RUN (>=1).
- SYNC_SIG_N, 8192, clocks per sync segment.
- START_PH, 0, phase loaded at every symbol boundary.
- GPIO_REG_WIDTH, 12, GPIO register width.
- SYNC_IN_BIT, 2, gpio_in bit carrying the trigger.
- SYNC_OUT_BIT, 0, gpio_out bit high during SYNC.
- RX_OUT_BIT, 4, gpio_out bit high during RUN.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- gpio_in  in  GPIO_REG_WIDTH  front-panel inputs (asynchronous).
- gpio_out  out  GPIO_REG_WIDTH  status outputs; only SYNC_OUT_BIT/RX_OUT_BIT ever driven.
- abort  in  1  return to IDLE next cycle.
- smp_stb  in  1  one accepted input sample this cycle.
- cfg_nsig  in  CNT_WIDTH  samples per symbol.
- cfg_nsymb  in  CNT_WIDTH  symbols per frame.
- cfg_nframes  in  CNT_WIDTH  frames per run; 0 = continuous.
- cfg_start_inc  in  PHASE_WIDTH  step increment at symbol 0.
- cfg_dph_inc  in  PHASE_WIDTH  step added per symbol.
- cfg_ch_inc  in  NCH*PHASE_WIDTH  per-channel base increment; ch k at [k*PHASE_WIDTH +: PHASE_WIDTH].
- cfg_ch_mode  in  NCH  1 = increment is base+step, 0 = base only.
- cfg_ch_dir  in  NCH  1 = subtract, 0 = add.
- ph_tdata  out  NCH*PHASE_WIDTH  phase per channel for the strobed sample.
- ph_tvalid  out  1  ph_tdata valid (one cycle per smp_stb in RUN).
- sym_start  out  1  pulse with ph_tvalid on the first sample of each symbol.
- frame_done  out  1  pulse after the last sample of a frame.
- sync_seg  out  CNT_WIDTH  current sync segment index.
- state  out  2  0 IDLE, 1 SYNC, 2 RUN, 3 DONE.

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE; all counters, phases, ph_tdata, sync_seg = 0.
  - ph_tvalid, sym_start, frame_done, gpio_out = 0.
  - Reset mid-operation returns to IDLE regardless of state.
- Trigger path:
  - gpio_in[SYNC_IN_BIT] passes a 2-flop synchroniser; trigger = rising edge of the synchronised bit.
  - Trigger is accepted only in IDLE; ignored in all other states.
- IDLE -> SYNC on trigger:
  - Latch all cfg_* inputs into shadow registers; config changes during a run have no effect.
  - cfg_nsig=0 or cfg_nsymb=0 is latched as 1.
  - sync_seg=0, clock counter=0.
- SYNC:
  - Counter runs every clk; at SYNC_SIG_N-1 it wraps and sync_seg increments.
  - After segment NSYNC_SEG-1 completes, go to RUN, initialising: sig_cnt=0, sym_cnt=0, frame_cnt=0, step=start_inc, all phases=START_PH.
  - gpio_out[SYNC_OUT_BIT]=1 throughout SYNC.
- RUN:
  - gpio_out[RX_OUT_BIT]=1. smp_stb ignored outside RUN.
  - On smp_stb, next cycle: ph_tvalid=1, ph_tdata = current phases (pre-advance); sym_start=1 if sig_cnt was 0.
  - Channel increment: inc_k = base_k + (mode_k ? step : 0). Phase advances by phase_k ± inc_k, modulo 2^PHASE_WIDTH, no saturation.
  - On a strobe with sig_cnt == nsig-1: sig_cnt=0, all phases=START_PH.
    - If sym_cnt == nsymb-1: sym_cnt=0, step=start_inc, frame_cnt++, frame_done pulse aligned with that ph_tvalid.
    - Otherwise: sym_cnt++, step += dph_inc (wraps).
  - Otherwise: sig_cnt++ and phases advance.
  - When frame_cnt reaches nframes (nframes != 0), go to DONE on that same cycle.
- DONE: gpio_out=0; one cycle, then IDLE.
- abort: highest priority after reset; any state -> IDLE next cycle; pulses cleared; phases hold.
- abort and trigger in the same cycle: abort wins; the trigger is discarded.

Test Plan:
- Reset then gpio_in[2] rising edge (held 5 clk) -> state=1 after 3 clk; gpio_out=12'h001 for 3*8192 clk; sync_seg steps 0,1,2; then state=2, gpio_out=12'h010.
- RUN with NCH=1, nsig=4, nsymb=2, start_inc=100, dph=50, base=0, mode=1, dir=0, strobe every clk -> ph_tdata 0,100,200,300,0,150,300,450,0,100...; sym_start on samples 0 and 4; frame_done on sample 7.
- nframes=2, nsig=3, nsymb=1 -> DONE after sample 5, IDLE next cycle; further smp_stb produce no ph_tvalid.
- dir=1, base=24'h000010, mode=0, START_PH=0 -> second phase 24'hFFFFF0 (wrap-around), third 24'hFFFFE0.
- Gap strobes (1 in 3 clk) -> ph_tvalid exactly one cycle after each strobe; phase sequence identical to the continuous case.
- abort mid-SYNC and mid-RUN -> IDLE next clk, gpio_out=0; a trigger in the abort cycle is ignored; a later trigger restarts cleanly; a cfg change during RUN leaves outputs unchanged.
